arbiter_matching_queue: RTL and testbench

//  Parametrised in-order tag queue matching arbiter grants to returning responses.
//  On each grant the arbiter pushes a TW-bit type/channel tag. The response path pops tags in order to route data.

---
 rtl/arbiter_matching_queue_if.sv | 33 +++
 rtl/arbiter_matching_queue.sv | 76 +++++++
 tb/tb_arbiter_matching_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_matching_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_matching_queue_if
// Description : Push/pop/status bundle between an arbiter and its tag queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbiter_matching_queue_if #(
    parameter int DN = 3,
    parameter int TW = 2
);
    logic          iFLUSH;
    logic          iWR_REQ;
    logic [TW-1:0] iWR_TYPE;
    logic          oWR_FULL;
    logic          oWR_ALMOST_FULL;
    logic          iRD_REQ;
    logic          oRD_VALID;
    logic [TW-1:0] oRD_TYPE;
    logic          oRD_EMPTY;
    logic [DN:0]   oCOUNT;
    logic          oOVERFLOW;

    modport master (
        output iFLUSH, iWR_REQ, iWR_TYPE, iRD_REQ,
        input  oWR_FULL, oWR_ALMOST_FULL, oRD_VALID, oRD_TYPE, oRD_EMPTY, oCOUNT, oOVERFLOW
    );

    modport slave (
        input  iFLUSH, iWR_REQ, iWR_TYPE, iRD_REQ,
        output oWR_FULL, oWR_ALMOST_FULL, oRD_VALID, oRD_TYPE, oRD_EMPTY, oCOUNT, oOVERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_matching_queue.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_matching_queue
// Description : In-order tag FIFO pairing arbiter grants with returning data.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_matching_queue #(
    parameter int D  = 8,
    parameter int DN = 3,
    parameter int TW = 2,
    parameter int AF = 6
) (
    input  wire logic               iCLOCK,
    input  wire logic               iRESET,
    arbiter_matching_queue_if.slave bus
);
    localparam logic [DN:0] c_DEPTH = (DN+1)'(D);
    localparam logic [DN:0] c_AF    = (DN+1)'(AF);

    logic [TW-1:0] r_tag [D];
    logic [DN:0]   r_wrPtr;
    logic [DN:0]   r_rdPtr;
    logic          r_overflow;

    logic [DN:0]   w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_rdAcc;
    logic          w_wrAcc;
    logic          w_wrDrop;

    // Extra pointer MSB separates full from empty once the indices coincide.
    assign w_count  = r_wrPtr - r_rdPtr;
    assign w_full   = (w_count == c_DEPTH);
    assign w_empty  = (w_count == '0);

    assign w_rdAcc  = bus.iRD_REQ & ~w_empty & ~bus.iFLUSH;
    assign w_wrAcc  = bus.iWR_REQ & ~bus.iFLUSH & (~w_full | w_rdAcc);
    assign w_wrDrop = bus.iWR_REQ & ~bus.iFLUSH & w_full & ~w_rdAcc;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < D; i++) begin
                r_tag[i] <= '0;
            end
        end else if (bus.iFLUSH) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // When full, a concurrent pop frees exactly the slot written here.
            if (w_wrAcc) begin
                r_tag[r_wrPtr[DN-1:0]] <= bus.iWR_TYPE;
                r_wrPtr                <= r_wrPtr + 1'b1;
            end
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_wrDrop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.oWR_FULL        = w_full;
    assign bus.oWR_ALMOST_FULL = (w_count >= c_AF);
    assign bus.oRD_EMPTY       = w_empty;
    assign bus.oRD_VALID       = ~w_empty & ~bus.iFLUSH;
    assign bus.oRD_TYPE        = r_tag[r_rdPtr[DN-1:0]];
    assign bus.oCOUNT          = w_count;
    assign bus.oOVERFLOW       = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_arbiter_matching_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_matching_queue
// Description : Scoreboard bench for the grant/response tag queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_matching_queue;
    localparam int c_D  = 8;
    localparam int c_DN = 3;
    localparam int c_TW = 3;
    localparam int c_AF = 6;

    logic iCLOCK = 1'b0;
    logic iRESET = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;

    logic [c_TW-1:0] sb [$];
    logic            mOvf = 1'b0;

    arbiter_matching_queue_if #(.DN(c_DN), .TW(c_TW)) bus ();

    arbiter_matching_queue #(.D(c_D), .DN(c_DN), .TW(c_TW), .AF(c_AF)) dut (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic wr, input logic [c_TW-1:0] t, input logic rd, input logic fl);
        bus.iWR_REQ  = wr;
        bus.iWR_TYPE = t;
        bus.iRD_REQ  = rd;
        bus.iFLUSH   = fl;
    endtask

    // Updates the reference model with the driven inputs, then crosses one edge.
    task automatic advance();
        logic rdAcc, wrAcc;
        rdAcc = bus.iRD_REQ && (sb.size() > 0) && !bus.iFLUSH;
        wrAcc = bus.iWR_REQ && !bus.iFLUSH && ((sb.size() < c_D) || rdAcc);
        if (bus.iFLUSH) begin
            sb.delete();
            mOvf = 1'b0;
        end else begin
            if (rdAcc) void'(sb.pop_front());
            if (wrAcc) sb.push_back(bus.iWR_TYPE);
            if (bus.iWR_REQ && !wrAcc) mOvf = 1'b1;
        end
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0);
        #1;
        nChecks++; if (bus.oRD_EMPTY !== 1'b1) begin nErrors++; $display("FAIL reset_empty got %b want 1", bus.oRD_EMPTY); end
        nChecks++; if (bus.oRD_VALID !== 1'b0) begin nErrors++; $display("FAIL reset_valid got %b want 0", bus.oRD_VALID); end
        nChecks++; if (bus.oWR_FULL !== 1'b0) begin nErrors++; $display("FAIL reset_full got %b want 0", bus.oWR_FULL); end
        nChecks++; if (bus.oWR_ALMOST_FULL !== 1'b0) begin nErrors++; $display("FAIL reset_afull got %b want 0", bus.oWR_ALMOST_FULL); end
        nChecks++; if (bus.oCOUNT !== 4'd0) begin nErrors++; $display("FAIL reset_count got %0d want 0", bus.oCOUNT); end
        nChecks++; if (bus.oRD_TYPE !== 3'd0) begin nErrors++; $display("FAIL reset_type got %0d want 0", bus.oRD_TYPE); end
        nChecks++; if (bus.oOVERFLOW !== 1'b0) begin nErrors++; $display("FAIL reset_ovf got %b want 0", bus.oOVERFLOW); end
        @(negedge iCLOCK);
        iRESET = 1'b0;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic test_in_order();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 3'(i), 0, 0);
            advance();
            nChecks++; if (bus.oCOUNT !== 4'(sb.size())) begin nErrors++; $display("FAIL order_push_count got %0d want %0d", bus.oCOUNT, sb.size()); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0);
            @(negedge iCLOCK);
            nChecks++; if (bus.oRD_VALID !== 1'b1) begin nErrors++; $display("FAIL order_valid got %b want 1", bus.oRD_VALID); end
            nChecks++; if (bus.oRD_TYPE !== sb[0]) begin nErrors++; $display("FAIL order_pop_type got %0d want %0d", bus.oRD_TYPE, sb[0]); end
            advance();
            nChecks++; if (bus.oCOUNT !== 4'(sb.size())) begin nErrors++; $display("FAIL order_pop_count got %0d want %0d", bus.oCOUNT, sb.size()); end
        end
        nChecks++; if (bus.oRD_EMPTY !== 1'b1) begin nErrors++; $display("FAIL order_end_empty got %b want 1", bus.oRD_EMPTY); end
        drive(0, '0, 1, 0);
        advance();
        nChecks++; if (bus.oCOUNT !== 4'd0 || bus.oRD_VALID !== 1'b0) begin nErrors++; $display("FAIL empty_pop count=%0d valid=%b want 0/0", bus.oCOUNT, bus.oRD_VALID); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < c_D; i++) begin
            drive(1, 3'(i), 0, 0);
            advance();
            nChecks++; if (bus.oCOUNT !== 4'(sb.size())) begin nErrors++; $display("FAIL fill_count got %0d want %0d", bus.oCOUNT, sb.size()); end
            nChecks++; if (bus.oWR_ALMOST_FULL !== (sb.size() >= c_AF)) begin nErrors++; $display("FAIL fill_afull got %b at count %0d", bus.oWR_ALMOST_FULL, sb.size()); end
            nChecks++; if (bus.oWR_FULL !== (sb.size() == c_D)) begin nErrors++; $display("FAIL fill_full got %b at count %0d", bus.oWR_FULL, sb.size()); end
        end
        drive(1, 3'd7, 0, 0);
        advance();
        nChecks++; if (bus.oOVERFLOW !== mOvf) begin nErrors++; $display("FAIL ovf_flag got %b want %b", bus.oOVERFLOW, mOvf); end
        nChecks++; if (bus.oCOUNT !== 4'(sb.size())) begin nErrors++; $display("FAIL ovf_count got %0d want %0d", bus.oCOUNT, sb.size()); end
        nChecks++; if (bus.oRD_TYPE !== sb[0]) begin nErrors++; $display("FAIL ovf_head got %0d want %0d", bus.oRD_TYPE, sb[0]); end
    endtask

    task automatic test_full_push_pop();
        drive(1, 3'd5, 1, 0);
        @(negedge iCLOCK);
        nChecks++; if (bus.oRD_TYPE !== sb[0]) begin nErrors++; $display("FAIL fullpp_pop_type got %0d want %0d", bus.oRD_TYPE, sb[0]); end
        advance();
        nChecks++; if (bus.oCOUNT !== 4'd8) begin nErrors++; $display("FAIL fullpp_count got %0d want 8", bus.oCOUNT); end
        for (int i = 0; i < 7; i++) begin
            drive(0, '0, 1, 0);
            @(negedge iCLOCK);
            nChecks++; if (bus.oRD_TYPE !== sb[0]) begin nErrors++; $display("FAIL fullpp_drain got %0d want %0d", bus.oRD_TYPE, sb[0]); end
            advance();
        end
        nChecks++; if (bus.oRD_TYPE !== 3'd5 || sb[0] !== 3'd5) begin nErrors++; $display("FAIL fullpp_head got %0d want 5", bus.oRD_TYPE); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'(i + 2), 0, 0);
            advance();
        end
        nChecks++; if (bus.oCOUNT !== 4'd4) begin nErrors++; $display("FAIL flush_pre_count got %0d want 4", bus.oCOUNT); end
        drive(1, 3'd6, 1, 1);
        #1;
        nChecks++; if (bus.oRD_VALID !== 1'b0) begin nErrors++; $display("FAIL flush_valid got %b want 0", bus.oRD_VALID); end
        advance();
        drive(0, '0, 0, 0);
        nChecks++; if (bus.oCOUNT !== 4'(sb.size())) begin nErrors++; $display("FAIL flush_count got %0d want %0d", bus.oCOUNT, sb.size()); end
        nChecks++; if (bus.oRD_EMPTY !== 1'b1) begin nErrors++; $display("FAIL flush_empty got %b want 1", bus.oRD_EMPTY); end
        nChecks++; if (bus.oOVERFLOW !== mOvf) begin nErrors++; $display("FAIL flush_ovf got %b want %b", bus.oOVERFLOW, mOvf); end
        advance();
        nChecks++; if (bus.oCOUNT !== 4'd0) begin nErrors++; $display("FAIL flush_push_discard got %0d want 0", bus.oCOUNT); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'($urandom_range(0, 7)), 0, 0);
            advance();
        end
        for (int i = 0; i < 40; i++) begin
            drive(1, 3'($urandom_range(0, 7)), 1, 0);
            @(negedge iCLOCK);
            nChecks++; if (bus.oRD_TYPE !== sb[0]) begin nErrors++; $display("FAIL wrap_type[%0d] got %0d want %0d", i, bus.oRD_TYPE, sb[0]); end
            advance();
            nChecks++; if (bus.oCOUNT !== 4'd3) begin nErrors++; $display("FAIL wrap_count[%0d] got %0d want 3", i, bus.oCOUNT); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0);
            @(negedge iCLOCK);
            nChecks++; if (bus.oRD_TYPE !== sb[0]) begin nErrors++; $display("FAIL wrap_drain got %0d want %0d", bus.oRD_TYPE, sb[0]); end
            advance();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'(i + 1), 0, 0);
            advance();
        end
        drive(0, '0, 0, 0);
        nChecks++; if (bus.oCOUNT !== 4'd5) begin nErrors++; $display("FAIL areset_pre_count got %0d want 5", bus.oCOUNT); end
        #1;
        iRESET = 1'b1;
        #1;
        sb.delete();
        mOvf = 1'b0;
        nChecks++; if (bus.oRD_EMPTY !== 1'b1) begin nErrors++; $display("FAIL areset_empty got %b want 1", bus.oRD_EMPTY); end
        nChecks++; if (bus.oCOUNT !== 4'd0) begin nErrors++; $display("FAIL areset_count got %0d want 0", bus.oCOUNT); end
        nChecks++; if (bus.oRD_VALID !== 1'b0) begin nErrors++; $display("FAIL areset_valid got %b want 0", bus.oRD_VALID); end
        nChecks++; if (bus.oRD_TYPE !== 3'd0) begin nErrors++; $display("FAIL areset_type got %0d want 0", bus.oRD_TYPE); end
        nChecks++; if (bus.oWR_ALMOST_FULL !== 1'b0 || bus.oWR_FULL !== 1'b0) begin nErrors++; $display("FAIL areset_flags af=%b full=%b want 0/0", bus.oWR_ALMOST_FULL, bus.oWR_FULL); end
        @(negedge iCLOCK);
        iRESET = 1'b0;
        @(posedge iCLOCK);
        #1;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill_overflow();
        test_full_push_pop();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
`default_nettype wire
